// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words MSB-first into a configuration flip-flop chain,
// optionally comparing the chain's returning bits against the stream to flag verify mismatches.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic              verify_q, verify_d;
  logic              err_q, err_d;
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    verify_d   = verify_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = FETCH;
        verify_d  = verify;
        err_d     = 1'b0;
        bit_cnt_d = '0;
      end
      FETCH: if (abort) state_d = IDLE;
      else if (s_valid) begin
        sr_d       = s_data;
        word_cnt_d = WW'(WORD_W);
        state_d    = SHIFT;
      end
      SHIFT: begin
        sr_d       = sr_q << 1;
        bit_cnt_d  = bit_cnt_q + BW'(1);
        word_cnt_d = word_cnt_q - WW'(1);
        err_d      = err_q | (verify_q & (ccff_tail != sr_q[WORD_W-1]));
        // reaching the chain length wins over word exhaustion, dropping any leftover bits
        state_d    = abort ? IDLE : (bit_cnt_q == LAST_BIT) ? DONE : (word_cnt_q == WW'(1)) ? FETCH : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      verify_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      verify_q   <= verify_d;
      err_q      <= err_d;
    end
  end
  assign s_ready   = state_q == FETCH;
  assign shift_en  = state_q == SHIFT;
  assign ccff_head = shift_en ? sr_q[WORD_W-1] : 1'b0;
  assign busy      = s_ready | shift_en;
  assign done      = state_q == DONE;
  assign err       = err_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed passes on an 8/8 and a 10/4 loader, each driving a behavioural chain,
// with expected head bits queued at stimulus time and popped on every shift cycle.
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic       a_start, a_verify, a_abort, a_valid, a_ready, a_head, a_tail, a_sh, a_busy, a_done, a_err;
  logic [7:0] a_data;
  logic       b_start, b_verify, b_abort, b_valid, b_ready, b_head, b_tail, b_sh, b_busy, b_done, b_err;
  logic [3:0] b_data;
  logic [7:0] chain_a = '0;
  logic [9:0] chain_b = '0;
  int a_words = 0, a_shifts = 0, a_dones = 0, b_words = 0, b_shifts = 0, b_dones = 0;
  int tests = 0, fails = 0;
  logic qa[$];
  logic qb[$];
  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut_a (
    .prog_clk(clk), .pReset_n(rst_n), .start(a_start), .verify(a_verify), .abort(a_abort),
    .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready), .ccff_head(a_head), .ccff_tail(a_tail),
    .shift_en(a_sh), .busy(a_busy), .done(a_done), .err(a_err));
  ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) dut_b (
    .prog_clk(clk), .pReset_n(rst_n), .start(b_start), .verify(b_verify), .abort(b_abort),
    .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready), .ccff_head(b_head), .ccff_tail(b_tail),
    .shift_en(b_sh), .busy(b_busy), .done(b_done), .err(b_err));
  assign a_tail = chain_a[7];
  assign b_tail = chain_b[9];
  always @(posedge clk) begin
    if (a_sh) chain_a <= {chain_a[6:0], a_head};
    if (b_sh) chain_b <= {chain_b[8:0], b_head};
    if (a_sh) a_shifts <= a_shifts + 1;
    if (b_sh) b_shifts <= b_shifts + 1;
    if (a_ready && a_valid) a_words <= a_words + 1;
    if (b_ready && b_valid) b_words <= b_words + 1;
    if (a_done) a_dones <= a_dones + 1;
    if (b_done) b_dones <= b_dones + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (a_sh) begin
      if (qa.size() == 0) check("a_extra_shift", 32'(a_sh), 0);
      else check("a_head", 32'(a_head), 32'(qa.pop_front()));
    end
    if (b_sh) begin
      if (qb.size() == 0) check("b_extra_shift", 32'(b_sh), 0);
      else check("b_head", 32'(b_head), 32'(qb.pop_front()));
    end
  endtask
  task automatic run_a(input logic v, input logic [7:0] w, input int stall, output int cyc, output logic err_pre);
    for (int i = 7; i >= 0; i--) qa.push_back(w[i]);
    a_data = w;
    a_verify = v;
    a_start = 1'b1;
    a_valid = stall == 0;
    cyc = 0;
    err_pre = 1'b0;
    do begin
      err_pre = a_err;
      tick();
      cyc++;
      a_start = 1'b0;
      a_abort = 1'b0;
      a_valid = cyc > stall;
      if (cyc <= stall) check("a_stall_shift_en", 32'(a_sh), 0);
    end while (!a_done && cyc < 60);
    a_valid = 1'b0;
  endtask
  initial begin
    int cyc, s0, w0, d0, idx;
    logic ep;
    logic [3:0] bw [3];
    logic [11:0] bstream;
    bw = '{4'hB, 4'h6, 4'hD};
    bstream = 12'hB6D;
    rst_n = 1'b0;
    {a_start, a_verify, a_abort, a_valid, a_data} = '0;
    {b_start, b_verify, b_abort, b_valid, b_data} = '0;
    tick();
    tick();
    check("reset_outputs", {a_ready, a_sh, a_head, a_busy, a_done, a_err, b_ready, b_sh, b_head, b_busy, b_done, b_err}, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_start", {a_busy, b_busy}, 0);
    s0 = a_shifts; w0 = a_words; d0 = a_dones;
    run_a(1'b0, 8'hA5, 0, cyc, ep);
    check("load_cycles", cyc, 10);
    check("load_done_outs", {a_done, a_busy, a_sh, a_ready, a_head}, 5'b10000);
    check("load_err", 32'(a_err), 0);
    tick();
    check("done_one_cycle", {a_done, a_busy}, 0);
    check("load_shifts", a_shifts - s0, 8);
    check("load_words", a_words - w0, 1);
    check("load_dones", a_dones - d0, 1);
    check("chain_after_load", chain_a, 8'hA5);
    check("qa_drained", qa.size(), 0);
    run_a(1'b1, 8'hA5, 0, cyc, ep);
    check("verify_match_err", 32'(a_err), 0);
    tick();
    run_a(1'b1, 8'hA4, 0, cyc, ep);
    check("verify_err_before_last", 32'(ep), 0);
    check("verify_mismatch_err", 32'(a_err), 1);
    tick();
    tick();
    tick();
    check("err_sticky", 32'(a_err), 1);
    s0 = a_shifts;
    run_a(1'b0, 8'hA5, 5, cyc, ep);
    check("stall_cycles", cyc, 15);
    check("load_clears_err", 32'(a_err), 0);
    tick();
    check("stall_shifts", a_shifts - s0, 8);
    check("chain_after_stall", chain_a, 8'hA5);
    s0 = a_shifts; d0 = a_dones;
    a_data = 8'h3C;
    for (int i = 7; i >= 0; i--) qa.push_back(a_data[i]);
    a_verify = 1'b0;
    a_start = 1'b1;
    a_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      a_start = 1'b0;
    end
    check("abort_in_shift", 32'(a_sh), 1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    a_valid = 1'b0;
    check("abort_idle", {a_busy, a_sh, a_done, a_ready}, 0);
    check("abort_shifts", a_shifts - s0, 4);
    tick();
    tick();
    check("abort_no_done", a_dones - d0, 0);
    qa.delete();
    a_abort = 1'b1;
    run_a(1'b0, 8'hA5, 0, cyc, ep);
    check("start_over_abort_cycles", cyc, 10);
    tick();
    check("chain_after_reload", chain_a, 8'hA5);
    for (int i = 0; i < 8; i++) qa.push_back(1'b0);
    a_data = 8'h00;
    a_verify = 1'b1;
    a_start = 1'b1;
    a_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      a_start = 1'b0;
    end
    check("verify_err_mid_pass", 32'(a_err), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", {a_ready, a_sh, a_head, a_busy, a_done, a_err}, 0);
    a_valid = 1'b0;
    qa.delete();
    d0 = a_dones;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("reset_needs_start", {a_busy, a_sh}, 0);
    check("reset_no_done", a_dones - d0, 0);
    s0 = a_shifts;
    run_a(1'b0, 8'hA5, 0, cyc, ep);
    check("post_reset_cycles", cyc, 10);
    tick();
    check("post_reset_shifts", a_shifts - s0, 8);
    check("chain_post_reset", chain_a, 8'hA5);
    for (int i = 11; i >= 2; i--) qb.push_back(bstream[i]);
    s0 = b_shifts; w0 = b_words;
    b_data = bw[0];
    b_start = 1'b1;
    b_valid = 1'b1;
    idx = 0;
    cyc = 0;
    do begin
      tick();
      cyc++;
      b_start = 1'b0;
      if (b_ready && idx < 3) begin
        b_data = bw[idx];
        idx++;
      end
    end while (!b_done && cyc < 60);
    b_valid = 1'b0;
    check("partial_cycles", cyc, 14);
    tick();
    check("partial_shifts", b_shifts - s0, 10);
    check("partial_words", b_words - w0, 3);
    check("qb_drained", qb.size(), 0);
    check("chain_b", chain_b, 10'h2DB);
    check("partial_err", 32'(b_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, giving the number of configuration flip-flops between ccff_head and ccff_tail (range 1..4096).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width (range 1..32).
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port pReset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1 bit: begin a pass; sampled only in IDLE.
REQ-006 SHALL have port verify, input, 1 bit: sampled with start; 1 selects a verify pass, 0 selects a load pass.
REQ-007 SHALL have port abort, input, 1 bit: terminate the current pass.
REQ-008 SHALL have port s_data, input, WORD_W bits: bitstream word, shifted MSB first.
REQ-009 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-010 SHALL have port s_ready, output, 1 bit: word accepted on the cycle where s_valid=1 and s_ready=1.
REQ-011 SHALL have port ccff_head, output, 1 bit: serial bit into the chain.
REQ-012 SHALL have port ccff_tail, input, 1 bit: serial bit out of the chain.
REQ-013 SHALL have port shift_en, output, 1 bit: clock enable for the chain; the chain advances one position on each prog_clk edge where shift_en=1.
REQ-014 SHALL have port busy, output, 1 bit: a pass is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes normally.
REQ-016 SHALL have port err, output, 1 bit: sticky verify-mismatch flag.

Function
REQ-017 SHALL implement the states IDLE, FETCH, SHIFT and DONE.
REQ-018 IDLE: when start=1, SHALL latch verify, clear err, clear bit_cnt, and move to FETCH; busy=0 in IDLE.
REQ-019 FETCH: SHALL drive s_ready=1 and shift_en=0; on handshake, SHALL load s_data into the shift register, set word_cnt=WORD_W and move to SHIFT; with no handshake it SHALL stay in FETCH, which stalls the chain.
REQ-020 SHIFT: SHALL drive ccff_head = shift register MSB and shift_en=1 on every cycle; on each edge it SHALL shift left by 1, increment bit_cnt and decrement word_cnt.
REQ-021 SHIFT exit on the same edge that bit_cnt reaches CHAIN_LEN: SHALL go to DONE, and any unshifted bits of the current word SHALL be discarded.
REQ-022 SHIFT exit when word_cnt reaches 0 with bit_cnt < CHAIN_LEN: SHALL go to FETCH.
REQ-023 Word consumption: a pass SHALL consume exactly ceil(CHAIN_LEN/WORD_W) words and SHALL deliver exactly CHAIN_LEN shift_en cycles.
REQ-024 Timing: each word SHALL cost one FETCH cycle plus its shift cycles, giving a minimum pass length of CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles from the start sample to the done pulse.
REQ-025 DONE: SHALL assert done=1 for exactly one cycle with busy=0 and shift_en=0, then return to IDLE.
REQ-026 busy SHALL be 1 in FETCH and SHIFT only.
REQ-027 s_ready SHALL be 1 only in FETCH.
REQ-028 Verify pass: the pass runs identically to a load pass; on each SHIFT cycle where ccff_tail != ccff_head, err SHALL be set on that edge.
REQ-029 err SHALL hold until the next accepted start or reset; a load pass SHALL leave err at 0 after its start.
REQ-030 abort=1 in FETCH or SHIFT SHALL take effect on the next edge: state to IDLE, shift_en=0, no done pulse, err held; the chain is left partially shifted.
REQ-031 abort in IDLE or DONE SHALL be ignored; abort with start in IDLE SHALL be ignored and start SHALL take effect.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 bit_cnt SHALL be $clog2(CHAIN_LEN+1) bits wide and word_cnt SHALL be $clog2(WORD_W+1) bits wide; neither counter SHALL wrap.
REQ-034 ccff_head SHALL be 0 outside SHIFT.

Reset
REQ-035 pReset_n=0 SHALL immediately force state IDLE, and s_ready, shift_en, ccff_head, busy, done and err to 0; the shift register and counters SHALL be cleared.
REQ-036 Reset asserted mid-pass SHALL abandon the pass, with no done pulse.
REQ-037 The first pass after pReset_n deasserts SHALL require a new start.

Verification
REQ-038 Load: CHAIN_LEN=8, WORD_W=8, start verify=0, word 0xA5 offered continuously -> 1 FETCH cycle, then 8 shift_en cycles with ccff_head 1,0,1,0,0,1,0,1, then done pulse 10 cycles after start; err=0.
REQ-039 Verify pass: after the REQ-038 load into an 8-FF chain model, verify pass with 0xA5 -> err stays 0; a second verify pass with 0xA4 -> err=1 after the 8th shift cycle.
REQ-040 Partial last word: CHAIN_LEN=10, WORD_W=4 -> 3 words accepted, exactly 10 shift_en cycles, last 2 LSBs of word 3 never driven on ccff_head.
REQ-041 Stall: s_valid held low for 5 cycles in FETCH -> shift_en=0 for those cycles; the chain model contents after done equal the unstalled case.
REQ-042 Abort and reset: abort on the 4th SHIFT cycle -> IDLE next cycle with no done pulse; separately, pReset_n pulsed low mid-SHIFT -> all outputs 0 immediately, and a start afterwards runs a full pass.
